render_frame_scheduler: RTL and testbench
=========================================

Name: render_frame_scheduler

Overview:
- Per-frame sequencer for the render pipeline. On each frame-start pulse it clears the back framebuffer, then launches the render pipeline once per object. Each launch is gated on pipeline ready and a non-empty MVP-matrix FIFO, and the block waits for pipeline finished before the next launch.
- When all objects are drawn it requests a buffer swap from the display side.
- It sits between the frame-timing logic (VGA / clear / swap) and the render pipeline's start/ready/finished handshake.

Parameters:
- MAX_NUM_OBJECTS_PER_FRAME, 1024: upper bound on objects per frame.
- OBJ_CNT_WIDTH, $clog2(MAX_NUM_OBJECTS_PER_FRAME+1): width of object count and index.
- TIMEOUT_CYCLES, 2**20: watchdog limit per wait state.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_frame_start  in  1  one-cycle pulse requesting a new frame.
- i_num_objects  in  OBJ_CNT_WIDTH  object count, sampled on the accepted i_frame_start.
- o_clear_req  out  1  level; framebuffer clear request.
- i_clear_done  in  1  clear complete.
- o_pipe_start  out  1  one-cycle pulse to render pipeline start.
- i_pipe_ready  in  1  pipeline idle and able to accept start.
- i_pipe_finished  in  1  pipeline finished the current object (pulse).
- i_mvp_fifo_empty  in  1  MVP-matrix FIFO empty.
- o_swap_req  out  1  level; buffer swap request.
- i_swap_ack  in  1  swap accepted.
- o_busy  out  1  high in every state except IDLE.
- o_obj_idx  out  OBJ_CNT_WIDTH  index of the object currently being rendered.
- o_frame_done  out  1  one-cycle pulse when the swap is acknowledged.
- o_overrun  out  1  one-cycle pulse when i_frame_start arrives while busy.
- o_timeout  out  1  sticky watchdog error flag.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, o_obj_idx=0, internal counters 0, o_timeout cleared. All outputs are registered.
- FSM states: IDLE, CLEAR, WAIT_GO, START, RENDER, SWAP.
- IDLE:
  - On i_frame_start, latch n = min(i_num_objects, MAX_NUM_OBJECTS_PER_FRAME) and set obj_idx=0.
  - Go to CLEAR; o_clear_req=1 from the next cycle.
- CLEAR:
  - Hold o_clear_req=1 until i_clear_done=1.
  - Then drop o_clear_req. If n==0 go to SWAP, else go to WAIT_GO.
- WAIT_GO:
  - When i_pipe_ready=1 and i_mvp_fifo_empty=0 in the same cycle, go to START.
  - No watchdog in this state; an empty FIFO stalls indefinitely.
- START:
  - Assert o_pipe_start for exactly 1 cycle, then go to RENDER.
- RENDER:
  - On i_pipe_finished, obj_idx+1.
  - If the new obj_idx==n go to SWAP, else go to WAIT_GO.
  - A finished arriving in the same cycle as START is ignored.
- SWAP:
  - Hold o_swap_req=1 until i_swap_ack=1.
  - Then drop o_swap_req, pulse o_frame_done for 1 cycle, go to IDLE.
- Latency:
  - i_frame_start at cycle T gives o_clear_req=1 at T+1.
  - i_clear_done at T gives o_pipe_start no earlier than T+2.
  - i_pipe_finished at T gives the next o_pipe_start no earlier than T+2.
- Overrun:
  - i_frame_start while o_busy=1 is dropped: no state change, o_overrun pulses next cycle.
  - i_frame_start in the same cycle that o_frame_done is asserted is accepted (the FSM is already in IDLE).
- Watchdog:
  - A cycle counter resets on every state entry and runs only in CLEAR, RENDER and SWAP.
  - Reaching TIMEOUT_CYCLES-1 sets o_timeout=1 (sticky until rst), drops all request outputs and returns to IDLE without o_frame_done.
- Reset mid-frame: immediate return to IDLE. No pulse is emitted on reset deassertion.
- o_obj_idx holds its last value in IDLE until the next accepted frame start.

Test Plan:
- Reset held 3 cycles then released, no stimulus -> all outputs 0 for 10 cycles; state IDLE.
- frame_start with i_num_objects=3, clear_done after 5 cycles, pipe_ready=1, FIFO non-empty, finished 20 cycles after each start -> exactly 3 o_pipe_start pulses; o_obj_idx steps 0→1→2→3; swap_req, then ack → one o_frame_done.
- i_num_objects=0 -> clear then swap directly; zero o_pipe_start pulses; o_frame_done after ack.
- i_mvp_fifo_empty=1 for 100 cycles before the 2nd object -> no start during the stall; start occurs 1 cycle after empty deasserts; o_timeout stays 0.
- frame_start pulsed during RENDER -> o_overrun pulse, object count unaffected. With TIMEOUT_CYCLES=64 and clear_done never asserted -> o_timeout=1 at cycle 64 of CLEAR, FSM back in IDLE, o_clear_req=0.
- i_num_objects=2000 -> clamped to 1024 starts; assert rst in RENDER at object 5 -> all outputs 0 asynchronously, next frame starts cleanly at obj_idx 0.

Source files
------------

// File: rtl/render_frame_scheduler.sv
// Per-frame render sequencer: clears the back buffer, launches the pipeline once per object,
// then requests a buffer swap. All outputs are registered.
module render_frame_scheduler #(
  parameter int MAX_NUM_OBJECTS_PER_FRAME = 1024,
  parameter int OBJ_CNT_WIDTH             = $clog2(MAX_NUM_OBJECTS_PER_FRAME + 1),
  parameter int TIMEOUT_CYCLES            = 2**20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_frame_start,
  input  logic [OBJ_CNT_WIDTH-1:0] i_num_objects,
  output logic                     o_clear_req,
  input  logic                     i_clear_done,
  output logic                     o_pipe_start,
  input  logic                     i_pipe_ready,
  input  logic                     i_pipe_finished,
  input  logic                     i_mvp_fifo_empty,
  output logic                     o_swap_req,
  input  logic                     i_swap_ack,
  output logic                     o_busy,
  output logic [OBJ_CNT_WIDTH-1:0] o_obj_idx,
  output logic                     o_frame_done,
  output logic                     o_overrun,
  output logic                     o_timeout
);

  // state    | meaning
  // IDLE     | waiting for an accepted frame start
  // CLEAR    | clear request held until clear done
  // WAIT_GO  | waiting for pipeline ready with a matrix available
  // START    | one-cycle pipeline start pulse
  // RENDER   | waiting for the pipeline to finish the current object
  // SWAP     | swap request held until acknowledged
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_WAIT_GO = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_RENDER  = 3'd4;
  localparam logic [2:0] ST_SWAP    = 3'd5;

  localparam int                       TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_WIDTH-1:0]     TMR_LOAD  = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [OBJ_CNT_WIDTH-1:0] MAX_OBJ   = OBJ_CNT_WIDTH'(MAX_NUM_OBJECTS_PER_FRAME);

  logic [2:0]               state_q, state_d;
  logic [OBJ_CNT_WIDTH-1:0] num_q, num_d;
  logic [OBJ_CNT_WIDTH-1:0] idx_q, idx_d;
  logic [TMR_WIDTH-1:0]     tmr_q, tmr_d;
  logic                     clear_req_q, clear_req_d;
  logic                     pipe_start_q, pipe_start_d;
  logic                     swap_req_q, swap_req_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overrun_q, overrun_d;
  logic                     timeout_q, timeout_d;
  logic                     wdog_run;
  logic                     wdog_hit;

  assign wdog_run = (state_q == ST_CLEAR) || (state_q == ST_RENDER) || (state_q == ST_SWAP);
  assign wdog_hit = wdog_run && (tmr_q == '0);

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    idx_d        = idx_q;
    timeout_d    = timeout_q;
    frame_done_d = 1'b0;
    overrun_d    = i_frame_start && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (i_frame_start) begin
          num_d   = (i_num_objects > MAX_OBJ) ? MAX_OBJ : i_num_objects;
          idx_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (i_clear_done) begin
          state_d = (num_q == '0) ? ST_SWAP : ST_WAIT_GO;
        end else if (wdog_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_GO: begin
        if (i_pipe_ready && !i_mvp_fifo_empty) state_d = ST_START;
      end
      ST_START: begin
        // a finished seen here belongs to an earlier launch and is ignored
        state_d = ST_RENDER;
      end
      ST_RENDER: begin
        if (i_pipe_finished) begin
          idx_d   = idx_q + OBJ_CNT_WIDTH'(1);
          state_d = (idx_d == num_q) ? ST_SWAP : ST_WAIT_GO;
        end else if (wdog_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_SWAP: begin
        if (i_swap_ack) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (wdog_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // watchdog down-counter reloads on every state entry
    if (state_d != state_q) begin
      tmr_d = TMR_LOAD;
    end else if (wdog_run && (tmr_q != '0)) begin
      tmr_d = tmr_q - TMR_WIDTH'(1);
    end else begin
      tmr_d = tmr_q;
    end

    clear_req_d  = (state_d == ST_CLEAR);
    pipe_start_d = (state_d == ST_START);
    swap_req_d   = (state_d == ST_SWAP);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      idx_q        <= '0;
      tmr_q        <= '0;
      clear_req_q  <= 1'b0;
      pipe_start_q <= 1'b0;
      swap_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      clear_req_q  <= clear_req_d;
      pipe_start_q <= pipe_start_d;
      swap_req_q   <= swap_req_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_clear_req  = clear_req_q;
  assign o_pipe_start = pipe_start_q;
  assign o_swap_req   = swap_req_q;
  assign o_busy       = busy_q;
  assign o_obj_idx    = idx_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Directed-plus-random bench for render_frame_scheduler; expectations come from frame-level
// rules (object counts, handshake latencies) rather than from the FSM structure.
module tb_render_frame_scheduler;

  logic        clk;
  logic        rst;
  logic        i_frame_start;
  logic [10:0] i_num_objects;
  logic        o_clear_req;
  logic        i_clear_done;
  logic        o_pipe_start;
  logic        i_pipe_ready;
  logic        i_pipe_finished;
  logic        i_mvp_fifo_empty;
  logic        o_swap_req;
  logic        i_swap_ack;
  logic        o_busy;
  logic [10:0] o_obj_idx;
  logic        o_frame_done;
  logic        o_overrun;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int exp_timeout = 0;
  bit aborted;

  render_frame_scheduler #(
    .MAX_NUM_OBJECTS_PER_FRAME(1024),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_frame_start(i_frame_start),
    .i_num_objects(i_num_objects),
    .o_clear_req(o_clear_req),
    .i_clear_done(i_clear_done),
    .o_pipe_start(o_pipe_start),
    .i_pipe_ready(i_pipe_ready),
    .i_pipe_finished(i_pipe_finished),
    .i_mvp_fifo_empty(i_mvp_fifo_empty),
    .o_swap_req(o_swap_req),
    .i_swap_ack(i_swap_ack),
    .o_busy(o_busy),
    .o_obj_idx(o_obj_idx),
    .o_frame_done(o_frame_done),
    .o_overrun(o_overrun),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_pipe_start) start_cnt <= start_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clear_req"},  32'(o_clear_req), 0);
    chk({tag, "_pipe_start"}, 32'(o_pipe_start), 0);
    chk({tag, "_swap_req"},   32'(o_swap_req), 0);
    chk({tag, "_busy"},       32'(o_busy), 0);
    chk({tag, "_obj_idx"},    32'(o_obj_idx), 0);
    chk({tag, "_frame_done"}, 32'(o_frame_done), 0);
    chk({tag, "_overrun"},    32'(o_overrun), 0);
    chk({tag, "_timeout"},    32'(o_timeout), 0);
  endtask

  // One whole frame as seen from the frame-timing and pipeline sides.
  // Latency arguments < 0 pick random values; object indices < 0 disable that feature.
  task automatic do_frame(input int nreq, input int clear_lat, input int fin_lat,
                          input int stall_obj, input int stall_len, input int ovr_obj,
                          input int abort_obj, input bit b2b, output bit was_aborted);
    int exp_n, s0, lat, gap, fin;
    was_aborted = 1'b0;
    exp_n = (nreq > 1024) ? 1024 : nreq;
    s0 = start_cnt;
    i_num_objects = 11'(nreq);
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    i_num_objects = 11'($urandom_range(0, 2047));
    chk("clear_req_rise", 32'(o_clear_req), 1);
    chk("busy_rise", 32'(o_busy), 1);
    chk("idx_reset", 32'(o_obj_idx), 0);
    chk("no_overrun_on_accept", 32'(o_overrun), 0);

    lat = (clear_lat >= 0) ? clear_lat : int'($urandom_range(0, 8));
    repeat (lat) begin
      step();
      chk("clear_req_hold", 32'(o_clear_req), 1);
    end
    i_clear_done = 1'b1;
    step();
    i_clear_done = 1'b0;
    chk("clear_req_drop", 32'(o_clear_req), 0);

    for (int k = 0; k < exp_n; k++) begin
      if (k == stall_obj) begin
        i_mvp_fifo_empty = 1'b1;
        i_pipe_ready = 1'b1;
        repeat (stall_len) begin
          step();
          chk("stall_no_start", 32'(o_pipe_start), 0);
        end
        chk("stall_no_timeout", 32'(o_timeout), 32'(exp_timeout));
        i_mvp_fifo_empty = 1'b0;
      end else begin
        gap = int'($urandom_range(0, 3));
        i_pipe_ready = 1'b0;
        repeat (gap) begin
          step();
          chk("gate_no_start", 32'(o_pipe_start), 0);
        end
        i_pipe_ready = 1'b1;
      end
      step();
      chk("pipe_start", 32'(o_pipe_start), 1);
      chk("idx_at_start", 32'(o_obj_idx), 32'(k));
      i_pipe_ready = 1'b0;
      i_pipe_finished = 1'($urandom_range(0, 1));
      step();
      i_pipe_finished = 1'b0;
      chk("start_one_cycle", 32'(o_pipe_start), 0);
      chk("idx_in_render", 32'(o_obj_idx), 32'(k));
      if (k == abort_obj) begin
        was_aborted = 1'b1;
        return;
      end
      fin = (fin_lat > 0) ? fin_lat : int'($urandom_range(2, 20));
      for (int c = 1; c < fin; c++) begin
        if (k == ovr_obj && c == 1) begin
          i_frame_start = 1'b1;
          step();
          i_frame_start = 1'b0;
          chk("overrun_pulse", 32'(o_overrun), 1);
          chk("overrun_idx_kept", 32'(o_obj_idx), 32'(k));
        end else begin
          step();
          chk("overrun_quiet", 32'(o_overrun), 0);
        end
      end
      i_pipe_finished = 1'b1;
      step();
      i_pipe_finished = 1'b0;
      chk("idx_step", 32'(o_obj_idx), 32'(k + 1));
      chk("timeout_level", 32'(o_timeout), 32'(exp_timeout));
    end

    chk("swap_req_rise", 32'(o_swap_req), 1);
    chk("start_count", 32'(start_cnt - s0), 32'(exp_n));
    lat = int'($urandom_range(0, 5));
    repeat (lat) begin
      step();
      chk("swap_req_hold", 32'(o_swap_req), 1);
      chk("no_early_done", 32'(o_frame_done), 0);
    end
    i_swap_ack = 1'b1;
    step();
    i_swap_ack = 1'b0;
    chk("swap_req_drop", 32'(o_swap_req), 0);
    chk("frame_done_pulse", 32'(o_frame_done), 1);
    chk("busy_drop", 32'(o_busy), 0);
    chk("idx_hold_idle", 32'(o_obj_idx), 32'(exp_n));
    if (!b2b) begin
      step();
      chk("frame_done_one_cycle", 32'(o_frame_done), 0);
      chk("idx_hold_idle2", 32'(o_obj_idx), 32'(exp_n));
    end
  endtask

  initial begin
    rst = 1'b1;
    i_frame_start = 1'b0;
    i_num_objects = '0;
    i_clear_done = 1'b0;
    i_pipe_ready = 1'b0;
    i_pipe_finished = 1'b0;
    i_mvp_fifo_empty = 1'b0;
    i_swap_ack = 1'b0;

    repeat (3) step();
    chk_all_zero("in_reset");
    rst = 1'b0;
    repeat (10) begin
      step();
      chk_all_zero("post_reset");
    end

    // three objects, fixed handshake latencies
    do_frame(3, 5, 20, -1, 0, -1, -1, 1'b0, aborted);
    // empty frame: clear then swap
    do_frame(0, -1, -1, -1, 0, -1, -1, 1'b0, aborted);
    // matrix FIFO empty for 100 cycles before the second object
    do_frame(3, -1, -1, 1, 100, -1, -1, 1'b0, aborted);
    // overrun during render, then a start in the frame_done cycle
    do_frame(4, -1, -1, -1, 0, 1, -1, 1'b1, aborted);
    do_frame(2, -1, -1, -1, 0, -1, -1, 1'b0, aborted);
    for (int f = 0; f < 6; f++) begin
      do_frame(int'($urandom_range(0, 12)), -1, -1, -1, 0,
               int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)), aborted);
    end
    // object count above the frame limit
    do_frame(2000, -1, 3, -1, 0, -1, -1, 1'b0, aborted);

    // clear never completes: watchdog fires after 64 cycles in CLEAR
    i_num_objects = 11'd3;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    chk("wd_clear_req", 32'(o_clear_req), 1);
    repeat (63) begin
      step();
      chk("wd_not_yet", 32'(o_timeout), 0);
    end
    chk("wd_clear_still_req", 32'(o_clear_req), 1);
    step();
    exp_timeout = 1;
    chk("wd_timeout_set", 32'(o_timeout), 1);
    chk("wd_clear_dropped", 32'(o_clear_req), 0);
    chk("wd_idle", 32'(o_busy), 0);
    chk("wd_no_frame_done", 32'(o_frame_done), 0);
    step();
    chk("wd_sticky", 32'(o_timeout), 1);
    do_frame(2, -1, -1, -1, 0, -1, -1, 1'b0, aborted);

    // reset mid-render at object 5
    do_frame(10, -1, -1, -1, 0, -1, 5, 1'b0, aborted);
    chk("abort_reached", 32'(aborted), 1);
    #3;
    rst = 1'b1;
    #1;
    exp_timeout = 0;
    chk_all_zero("async_reset");
    step();
    step();
    rst = 1'b0;
    repeat (5) begin
      step();
      chk_all_zero("after_reset");
    end
    do_frame(3, -1, -1, -1, 0, -1, -1, 1'b0, aborted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
